// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// Purpose: Pong match controller sequencing IDLE/SERVE/PLAY/POINT/OVER, scores and serve direction.
// Latency: Moore outputs registered on i_Clk; i_Serve rise to state change is 3 edges (2 sync + 1 edge/state).
// Backpressure: none; misses act only in PLAY, serve_edge only in IDLE/SERVE/OVER. Build option: AUTO_SERVE_EN.
module game_sequencer #(
    parameter int p_SERVE_FRAMES = 60,
    parameter int p_POINT_FRAMES = 90,
    parameter int p_WIN_SCORE    = 9
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VReset,
    input  logic       i_Serve,
    input  logic       i_Miss_Left,
    input  logic       i_Miss_Right,
    output logic       o_Ball_Enable,
    output logic       o_Ball_Reset,
    output logic       o_Serve_HDir,
    output logic [3:0] o_Score_Left,
    output logic [3:0] o_Score_Right,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [7:0] SERVE_LAST = 8'(p_SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(p_POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(p_WIN_SCORE);
`ifndef AUTO_SERVE_EN
    // Counter parks here once the serve hold is over, marking "serve allowed".
    localparam logic [7:0] SERVE_DONE = 8'(p_SERVE_FRAMES);
`endif

    logic       sync1_q, sync2_q, serve_prev_q;
    logic       serve_edge;
    logic [2:0] state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       hdir_q, hdir_d;
    logic       ball_en_q, ball_en_d;
    logic       ball_rst_q, ball_rst_d;
    logic       over_q, over_d;

    // Two-flop synchronizer on the raw serve switch plus a rising-edge history flop.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            serve_prev_q <= 1'b0;
        end else begin
            sync1_q      <= i_Serve;
            sync2_q      <= sync1_q;
            serve_prev_q <= sync2_q;
        end
    end

    assign serve_edge = sync2_q & ~serve_prev_q;

    // State, score, direction and frame counter registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= 8'd0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            hdir_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hdir_q    <= hdir_d;
        end
    end

    // Next state plus the score/direction updates that ride on each transition.
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hdir_d    = hdir_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (serve_edge) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    hdir_d    = 1'b1;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
`ifdef AUTO_SERVE_EN
                if (i_VReset && (frame_q == SERVE_LAST)) begin
                    state_d = ST_PLAY;
                end
`else
                // An early serve_edge is simply dropped: only a press after the hold counts.
                if (serve_edge && (frame_q == SERVE_DONE)) begin
                    state_d = ST_PLAY;
                end
`endif
            end
            ST_PLAY: begin
                if (i_Miss_Left && i_Miss_Right) begin
                    state_d = ST_POINT;
                end else if (i_Miss_Left) begin
                    score_r_d = (score_r_q == WIN) ? WIN : score_r_q + 4'd1;
                    hdir_d    = 1'b0;
                    state_d   = ST_POINT;
                end else if (i_Miss_Right) begin
                    score_l_d = (score_l_q == WIN) ? WIN : score_l_q + 4'd1;
                    hdir_d    = 1'b1;
                    state_d   = ST_POINT;
                end
            end
            ST_POINT: begin
                if (i_VReset && (frame_q == POINT_LAST)) begin
                    state_d = ((score_l_q == WIN) || (score_r_q == WIN)) ? ST_OVER : ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame counter: restarts on every state entry, counts frame pulses in SERVE/POINT only.
    always_comb begin
        frame_d = frame_q;
        if (state_d != state_q) begin
            frame_d = 8'd0;
        end else if (i_VReset && (state_q == ST_POINT)) begin
            frame_d = frame_q + 8'd1;
        end else if (i_VReset && (state_q == ST_SERVE)) begin
`ifdef AUTO_SERVE_EN
            frame_d = frame_q + 8'd1;
`else
            // Hold at the done value so a long wait for the player never wraps.
            if (frame_q != SERVE_DONE) begin
                frame_d = frame_q + 8'd1;
            end
`endif
        end
    end

    // Moore output decode from the upcoming state so outputs flip on the same edge as the state.
    always_comb begin
        ball_en_d  = 1'b0;
        ball_rst_d = 1'b1;
        over_d     = 1'b0;
        case (state_d)
            ST_PLAY: begin
                ball_en_d  = 1'b1;
                ball_rst_d = 1'b0;
            end
            ST_POINT: begin
                ball_rst_d = 1'b0;
            end
            ST_OVER: begin
                over_d = 1'b1;
            end
            default: begin
                ball_en_d  = 1'b0;
                ball_rst_d = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            ball_en_q  <= 1'b0;
            ball_rst_q <= 1'b1;
            over_q     <= 1'b0;
        end else begin
            ball_en_q  <= ball_en_d;
            ball_rst_q <= ball_rst_d;
            over_q     <= over_d;
        end
    end

    assign o_Ball_Enable = ball_en_q;
    assign o_Ball_Reset  = ball_rst_q;
    assign o_Serve_HDir  = hdir_q;
    assign o_Score_Left  = score_l_q;
    assign o_Score_Right = score_r_q;
    assign o_Game_Over   = over_q;
    assign o_State       = state_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Match-level controller for Pong. It gates ball motion, holds the ball at centre during serves, detects points from miss strobes, keeps both scores and declares game over. It sits between the VGA timing block (frame pulse) and the ball and direction logic, and sequences them through serve, play, point-pause and game-over phases.

## Interface

Parameters:
- p_SERVE_FRAMES, 60: frames the ball is held centred before it may launch (1..255).
- p_POINT_FRAMES, 90: frames the ball is frozen after a point (1..255).
- p_WIN_SCORE, 9: score that ends the match (1..15).

Ports:
- i_Clk  in  1  pixel clock; the only clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_VReset  in  1  one-cycle pulse at the start of each frame.
- i_Serve  in  1  raw serve switch level (asynchronous, active-high).
- i_Miss_Left  in  1  ball passed the left edge; level, sampled every cycle.
- i_Miss_Right  in  1  ball passed the right edge; level, sampled every cycle.
- o_Ball_Enable  out  1  ball position counters may advance.
- o_Ball_Reset  out  1  force ball to centre.
- o_Serve_HDir  out  1  launch direction: 0 = toward left, 1 = toward right.
- o_Score_Left  out  4  left player score.
- o_Score_Right  out  4  right player score.
- o_Game_Over  out  1  match finished.
- o_State  out  3  state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

## Operation

- **Serve input:** i_Serve passes through a 2-FF synchronizer, then a rising-edge detector, giving `serve_edge` (one cycle wide).
- **Frame counter:** 8 bits. Cleared on every state entry. Increments on i_VReset only in SERVE and POINT. "Elapsed" means the counter equals N-1 while i_VReset is high.
- **IDLE:** o_Ball_Reset=1, o_Ball_Enable=0.
  - serve_edge: clear both scores, o_Serve_HDir=1, go to SERVE.
- **SERVE:** o_Ball_Reset=1, o_Ball_Enable=0.
  - When p_SERVE_FRAMES has elapsed, go to PLAY (see Configuration).
- **PLAY:** o_Ball_Reset=0, o_Ball_Enable=1.
  - i_Miss_Left only: o_Score_Right+1 (saturating at p_WIN_SCORE), o_Serve_HDir=0, go to POINT.
  - i_Miss_Right only: o_Score_Left+1 (saturating), o_Serve_HDir=1, go to POINT.
  - Both misses in the same cycle: no score change, o_Serve_HDir unchanged, go to POINT (a let).
- **POINT:** o_Ball_Enable=0, o_Ball_Reset=0; the ball stays frozen where it is.
  - When p_POINT_FRAMES has elapsed: if either score equals p_WIN_SCORE, go to OVER; otherwise go to SERVE.
- **OVER:** o_Game_Over=1, o_Ball_Reset=1, o_Ball_Enable=0.
  - serve_edge: clear scores, o_Serve_HDir=1, go to SERVE.
- **Out-of-state events:** miss inputs are ignored outside PLAY. serve_edge is ignored in PLAY and POINT.
- **Undefined encodings (5-7):** go to IDLE on the next clock.

## Timing

- Reset values (asynchronous):
  - state IDLE, frame counter 0
  - o_Ball_Reset=1, o_Ball_Enable=0, o_Serve_HDir=1
  - both scores 0, o_Game_Over=0, o_State=0
- Outputs are Moore, registered on i_Clk; state, score and direction update on the same edge.
- A miss sampled high at edge N makes o_State=3 and the new score visible after edge N; o_Ball_Enable is 0 from then on.
- Serve latency: i_Serve rising to the state change is 3 clock edges (2 synchronizer + 1 edge/state).
- SERVE lasts exactly p_SERVE_FRAMES i_VReset pulses; leaving the state happens on the edge that samples the last pulse. The same rule applies to POINT with p_POINT_FRAMES.
- i_Reset asserted mid-frame or mid-state returns the block to IDLE immediately. Partial frame counts and scores are discarded.

## Configuration

- Macro: `AUTO_SERVE_EN`.
- **Defined:** SERVE goes to PLAY as soon as p_SERVE_FRAMES has elapsed; serve_edge is ignored in SERVE.
- **Not defined:** after the frames have elapsed, SERVE waits in place for serve_edge and then goes to PLAY on the next edge. A serve_edge that arrives before the frames have elapsed is discarded, not latched.

## Test plan

- **Reset and first serve:** reset, then pulse i_Serve.
  - State 0, then 1 three clocks later.
  - With AUTO_SERVE_EN and p_SERVE_FRAMES=4: PLAY after the 4th i_VReset; o_Ball_Enable goes 0→1.
- **Left miss:** in PLAY, i_Miss_Left=1 for one cycle.
  - o_Score_Right 0→1, o_Serve_HDir=0, state 3.
  - After p_POINT_FRAMES pulses, state 1.
- **Simultaneous misses:** both misses high in one PLAY cycle.
  - State 3, scores unchanged, o_Serve_HDir unchanged.
- **Win:** p_WIN_SCORE=2, two right misses.
  - o_Score_Left=2; after the POINT pause, state 4 and o_Game_Over=1.
  - A further i_Serve pulse gives scores 0, state 1, o_Game_Over=0.
- **Reset mid-operation:** assert i_Reset in POINT with the frame counter at 3.
  - All outputs return to reset values asynchronously.
  - An i_VReset arriving while i_Reset is held has no effect.
- **Manual serve (AUTO_SERVE_EN not defined):** i_Serve pulsed during the SERVE frame count.
  - Stays in state 1 after the count elapses.
  - A second pulse after the count enters PLAY three clocks later.
